uart_gen2: RTL
==============

UART_GEN2 -- requirements
Module: uart_gen2

Interface
REQ-001 SHALL have parameter DW, default 8: maximum data bits per frame, range 5..9.
REQ-002 SHALL have parameter OVS, default 16: oversample ticks per bit, even, at least 8.
REQ-003 SHALL have parameter RX_DEPTH, default 4: RX FIFO entries, a power of 2.
REQ-004 SHALL have parameter DIV_W, default 16: width of baud_div.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port baud_div, input, DIV_W bits: the oversample tick period is baud_div+1 clk cycles.
REQ-008 SHALL have port cfg, input, 6 bits: {stop2, par_en, par_odd, len[2:0]}; data bits = 5+len, clamped to DW.
REQ-009 SHALL have port tx_data, input, DW bits: word to send, LSB first; bits at or above the data length are ignored.
REQ-010 SHALL have port tx_valid, input, 1 bit, and port tx_ready, output, 1 bit: the TX handshake.
REQ-011 SHALL have port tx_o, output, 1 bit: serial out, idle high.
REQ-012 SHALL have port rx_i, input, 1 bit: asynchronous serial in.
REQ-013 SHALL have port rx_data, output, DW bits: FIFO head data, right-justified, upper bits zero.
REQ-014 SHALL have port rx_perr, output, 1 bit, and port rx_ferr, output, 1 bit: parity and framing error of the FIFO head word.
REQ-015 SHALL have port rx_valid, output, 1 bit, and port rx_ready, input, 1 bit: the RX FIFO pop handshake.
REQ-016 SHALL have port rx_overrun, output, 1 bit, and port ovr_clr, input, 1 bit: sticky overrun flag and its clear pulse.

Function
REQ-017 The tick generator SHALL count 0..baud_div and pulse a tick for one cycle at the terminal count; baud_div=0 gives a tick every cycle; TX and RX share it.
REQ-018 TX states SHALL be IDLE, START, DATA, PARITY, STOP; tx_ready=1 only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
REQ-019 On accept, TX SHALL latch tx_data and cfg; later cfg changes do not affect the frame in flight.
REQ-020 Each TX bit SHALL last exactly OVS ticks; bit order is start(0), data LSB first, optional parity, then 1 stop bit (2 if stop2); tx_o=1 in IDLE.
REQ-021 Parity SHALL be XOR of the data bits when par_odd=0 (even) and its inverse when par_odd=1; PARITY is skipped when par_en=0.
REQ-022 After the last stop bit TX SHALL return to IDLE; a new accept is then possible on the next cycle.
REQ-023 rx_i SHALL pass through a 2-flop synchroniser with reset value 1.
REQ-024 RX states SHALL be IDLE, START, DATA, PARITY, STOP; RX latches cfg when a start is detected.
REQ-025 RX IDLE SHALL detect a start only on a high-to-low transition of the synchronised input; a line held low never retriggers.
REQ-026 Each RX bit value SHALL be the 2-of-3 majority of samples taken at ticks OVS/2-1, OVS/2 and OVS/2+1 within the bit.
REQ-027 A start bit voting 1 SHALL be a false start: RX returns to IDLE and pushes nothing.
REQ-028 RX SHALL set perr when the parity vote mismatches the expected parity, and perr=0 when par_en=0.
REQ-029 RX SHALL set ferr when the first stop bit votes 0; the second stop bit is never checked.
REQ-030 At the stop-bit vote, RX SHALL push {ferr, perr, data} into the FIFO and enter IDLE the same cycle.
REQ-031 The FIFO SHALL be first-word-fall-through: rx_valid = not empty, and the head word appears on the cycle after its push.
REQ-032 A FIFO pop SHALL occur when rx_valid and rx_ready are both high.
REQ-033 A push while the FIFO is full and not popping SHALL drop the word and set rx_overrun.
REQ-034 A simultaneous push and pop when the FIFO is full SHALL succeed without setting overrun.
REQ-035 ovr_clr SHALL clear rx_overrun; a set in the same cycle wins.
REQ-036 FIFO pointers SHALL wrap modulo RX_DEPTH.

Reset
REQ-037 While rst_n=0 at a clk edge, the design SHALL reset: tx_o=1, tx_ready=1, rx_valid=0, rx_overrun=0, rx_perr=0, rx_ferr=0, rx_data=0, FIFO empty, both FSMs IDLE, tick counter 0.
REQ-038 A reset mid-frame SHALL abort the frame: tx_o is high on the first cycle after the reset edge and a partial RX word is never pushed.

Structure
REQ-039 Package uart_gen2_pkg SHALL hold the TX and RX state enums, the cfg bit-index constants and the 3-sample majority function.
REQ-040 Sub-module uart_gen2_fifo SHALL implement the RX FIFO, parametrised by width (DW+2) and depth.

Verification
REQ-041 Loopback test: baud_div=0, cfg len=3, no parity, 1 stop, send 0xA5 -> tx_o frame lasts 160 cycles; rx_data=0xA5, perr=0, ferr=0.
REQ-042 Parity test: len=2 (7 bits), par_en=1, par_odd=1, send 0x55 -> parity bit 1; flipping the parity bit on the line gives rx_perr=1.
REQ-043 Framing test: stop bit driven 0 -> word pushed with ferr=1; no new start is detected until rx_i returns high.
REQ-044 Overrun test: rx_ready=0, 5 frames 0x01..0x05 -> FIFO holds 0x01..0x04, rx_overrun=1; ovr_clr clears it.
REQ-045 Glitch test: rx_i low for 3 ticks -> false start, no push, RX back in IDLE.
REQ-046 Reset test: rst_n=0 during the TX data phase and during RX DATA -> tx_o=1, tx_ready=1, FIFO empty, no spurious rx_valid.

Source files
------------

// File: rtl/uart_gen2_pkg.sv
// uart_gen2_pkg: shared definitions for the uart_gen2 block.
//   tx_state_t / rx_state_t : transmitter and receiver FSM states
//   CFG_*                    : bit positions inside the 6-bit cfg word
//   maj3()                   : 2-of-3 majority vote used for RX bit decisions
//   data_bits()              : data-bit count from cfg.len, clamped to the datapath width
package uart_gen2_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int CFG_STOP2   = 5;
  localparam int CFG_PAR_EN  = 4;
  localparam int CFG_PAR_ODD = 3;
  localparam int CFG_LEN_MSB = 2;
  localparam int CFG_LEN_LSB = 0;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [3:0] data_bits(input logic [2:0] len, input int dw);
    int n;
    n = 5 + int'(len);
    if (n > dw) n = dw;
    return 4'(n);
  endfunction

endpackage

// File: rtl/uart_gen2_fifo.sv
// uart_gen2_fifo: first-word-fall-through receive FIFO with sticky overrun.
//   clk, rst_n       : clock, synchronous active-low reset (pointers/count/flag only)
//   push, push_data  : write request and word
//   pop_ready        : consumer ready; a pop happens when valid && pop_ready
//   ovr_clr          : clears the overrun flag (a same-cycle set wins)
//   head, valid      : head word (forced to zero when empty) and not-empty flag
//   overrun          : set when a push is dropped because the FIFO is full
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module uart_gen2_fifo
  import uart_gen2_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  input  logic         ovr_clr,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid & pop_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign head  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      if (push & full & ~pop) overrun <= 1'b1;
      else if (ovr_clr)       overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_gen2.sv
// uart_gen2: configurable UART transmitter/receiver with RX FIFO.
//   clk, rst_n          : clock, synchronous active-low reset
//   baud_div            : oversample tick period is baud_div+1 clk cycles
//   cfg                 : {stop2, par_en, par_odd, len[2:0]}, data bits = 5+len (clamped to DW)
//   tx_data/tx_valid/tx_ready : transmit handshake, word sent LSB first
//   tx_o                : serial output, idle high
//   rx_i                : asynchronous serial input
//   rx_data/rx_perr/rx_ferr   : FIFO head word and its parity/framing flags
//   rx_valid/rx_ready   : FIFO pop handshake
//   rx_overrun/ovr_clr  : sticky overrun flag and its clear
module uart_gen2
  import uart_gen2_pkg::*;
#(
  parameter int DW       = 8,
  parameter int OVS      = 16,
  parameter int RX_DEPTH = 4,
  parameter int DIV_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [5:0]       cfg,
  input  logic [DW-1:0]    tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_o,
  input  logic             rx_i,
  output logic [DW-1:0]    rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  input  logic             ovr_clr
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_S0   = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVS / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVS / 2 + 1);

  function automatic logic [DW-1:0] len_mask(input logic [3:0] n);
    return ~({DW{1'b1}} << n);
  endfunction

  logic [3:0] cfg_nbits;
  assign cfg_nbits = data_bits(cfg[CFG_LEN_MSB:CFG_LEN_LSB], DW);

  // ---- oversample tick generator ----
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt >= baud_div);

  always_ff @(posedge clk) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---- transmitter ----
  tx_state_t     tx_state;
  logic [TW-1:0] tx_tcnt;
  logic [3:0]    tx_bit;
  logic [3:0]    tx_nbits;
  logic [DW-1:0] tx_sh;
  logic          tx_par;
  logic          tx_par_en;
  logic          tx_stop2;
  logic          tx_stop_2nd;
  logic          tx_accept;
  logic          tx_bit_end;

  assign tx_accept  = tx_valid & tx_ready;
  assign tx_bit_end = tick & (tx_tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_ready    <= 1'b1;
      tx_o        <= 1'b1;
      tx_tcnt     <= '0;
      tx_bit      <= '0;
      tx_stop_2nd <= 1'b0;
    end else begin
      if ((tx_state != TX_IDLE) && tick)
        tx_tcnt <= (tx_tcnt == T_LAST) ? '0 : tx_tcnt + TW'(1);
      case (tx_state)
        TX_IDLE: begin
          if (tx_accept) begin
            tx_state    <= TX_START;
            tx_ready    <= 1'b0;
            tx_o        <= 1'b0;
            tx_tcnt     <= '0;
            tx_bit      <= '0;
            tx_stop_2nd <= 1'b0;
            tx_sh       <= tx_data & len_mask(cfg_nbits);
            tx_nbits    <= cfg_nbits;
            tx_par      <= (^(tx_data & len_mask(cfg_nbits))) ^ cfg[CFG_PAR_ODD];
            tx_par_en   <= cfg[CFG_PAR_EN];
            tx_stop2    <= cfg[CFG_STOP2];
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state <= TX_DATA;
            tx_o     <= tx_sh[0];
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit == tx_nbits - 4'd1) begin
              if (tx_par_en) begin
                tx_state <= TX_PARITY;
                tx_o     <= tx_par;
              end else begin
                tx_state <= TX_STOP;
                tx_o     <= 1'b1;
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              tx_o   <= tx_sh[1];
              tx_sh  <= tx_sh >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_state <= TX_STOP;
            tx_o     <= 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_stop2 && !tx_stop_2nd) begin
              tx_stop_2nd <= 1'b1;
            end else begin
              tx_state <= TX_IDLE;
              tx_ready <= 1'b1;
            end
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_ready <= 1'b1;
          tx_o     <= 1'b1;
        end
      endcase
    end
  end

  // ---- receiver: input synchroniser ----
  logic rx_sync_p0;
  logic rx_sync_p1;
  logic rx_prev;

  // ---- receiver: bit FSM ----
  rx_state_t     rx_state;
  logic [TW-1:0] rx_tcnt;
  logic [3:0]    rx_bit;
  logic [3:0]    rx_nbits;
  logic [DW-1:0] rx_sh;
  logic          rx_par_en;
  logic          rx_par_odd;
  logic          rx_perr_r;
  logic          rx_samp0;
  logic          rx_samp1;
  logic          rx_vote;
  logic          rx_vote_now;
  logic          rx_push;
  logic [DW+1:0] rx_word;

  // Third sample is the live synchronised value, so the vote resolves on that tick.
  assign rx_vote     = maj3(rx_samp0, rx_samp1, rx_sync_p1);
  assign rx_vote_now = tick & (rx_tcnt == T_S2);
  assign rx_push     = (rx_state == RX_STOP) & rx_vote_now;
  assign rx_word     = {~rx_vote, rx_perr_r, rx_sh};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_tcnt    <= '0;
      rx_bit     <= '0;
    end else begin
      rx_sync_p0 <= rx_i;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev    <= rx_sync_p1;
      if (rx_state == RX_IDLE) begin
        // Only a falling edge starts a frame; a line parked low stays ignored.
        if (rx_prev && !rx_sync_p1) begin
          rx_state   <= RX_START;
          rx_tcnt    <= '0;
          rx_bit     <= '0;
          rx_sh      <= '0;
          rx_perr_r  <= 1'b0;
          rx_nbits   <= cfg_nbits;
          rx_par_en  <= cfg[CFG_PAR_EN];
          rx_par_odd <= cfg[CFG_PAR_ODD];
        end
      end else if (tick) begin
        rx_tcnt <= (rx_tcnt == T_LAST) ? '0 : rx_tcnt + TW'(1);
        if (rx_tcnt == T_S0) rx_samp0 <= rx_sync_p1;
        if (rx_tcnt == T_S1) rx_samp1 <= rx_sync_p1;
        if (rx_tcnt == T_S2) begin
          case (rx_state)
            RX_START:  if (rx_vote) rx_state <= RX_IDLE;
            RX_DATA:   rx_sh <= rx_sh | (DW'(rx_vote) << rx_bit);
            RX_PARITY: rx_perr_r <= rx_vote ^ (^rx_sh) ^ rx_par_odd;
            // Second stop bit is left to look like idle line.
            RX_STOP:   rx_state <= RX_IDLE;
            default:   ;
          endcase
        end
        if (rx_tcnt == T_LAST) begin
          case (rx_state)
            RX_START: begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
            RX_DATA: begin
              if (rx_bit == rx_nbits - 4'd1)
                rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
              else
                rx_bit <= rx_bit + 4'd1;
            end
            RX_PARITY: rx_state <= RX_STOP;
            RX_STOP:   ;
            default:   rx_state <= RX_IDLE;
          endcase
        end
      end
    end
  end

  // ---- receive FIFO ----
  logic [DW+1:0] fifo_head;

  uart_gen2_fifo #(
    .W     (DW + 2),
    .DEPTH (RX_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_word),
    .pop_ready (rx_ready),
    .ovr_clr   (ovr_clr),
    .head      (fifo_head),
    .valid     (rx_valid),
    .overrun   (rx_overrun)
  );

  assign rx_data = fifo_head[DW-1:0];
  assign rx_perr = fifo_head[DW];
  assign rx_ferr = fifo_head[DW+1];

endmodule
